pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic elastic pipeline stage register. Replaces the fixed, enable-only inter-stage registers between IF/ID/EX/MEM/WB with one parametrised block. Carries a data bundle and a control bundle per stage, with valid/ready handshake, synchronous flush that turns the stage into a bubble, and a saturating stall counter. Sits between any two adjacent pipeline stages. The hazard unit drives `flush`; the downstream stage drives `out_ready`.

## Interface
- `DATA_W`, default 104: width of the data bundle (PC, operands, immediate, register indices, funct fields).
- `CTRL_W`, default 6: width of the control bundle (ALUSrc, ALUOp, Branch, RegWrite, MemToReg, …). Zeroed on every bubble.
- `CNT_W`, default 16: width of the stall counter.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous squash of all stage contents.
- `in_valid`  in  1  upstream holds a valid entry.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_data`  in  DATA_W  upstream data bundle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  stage output is valid.
- `out_ready`  in  1  downstream consumes the entry this cycle.
- `out_data`  out  DATA_W  registered data bundle.
- `out_ctrl`  out  CTRL_W  registered control bundle. It is 0 whenever `out_valid` = 0.
- `stall_cnt`  out  CNT_W  cycles spent with `out_valid` && !`out_ready`.

## Operation
- **Transfers:**
  - Input transfer: `in_valid` && `in_ready` at a rising edge.
  - Output transfer: `out_valid` && `out_ready` at a rising edge.
- **Main entry load:** the main entry loads when it is empty or being consumed (!`out_valid` || `out_ready`).
  - With a pending input transfer, the main entry takes `in_data`/`in_ctrl` and sets `out_valid` = 1.
  - Otherwise `out_valid` goes to 0, `out_ctrl` goes to 0, and `out_data` holds its last value.
- **Hold:** while `out_valid` && !`out_ready`, the main entry holds its data and control.
- **Flush:** on a cycle with `flush` = 1:
  - `out_valid` = 0, `out_ctrl` = 0, and every internal entry is invalidated.
  - Any input transfer in the same cycle is completed and discarded.
  - Flush has priority over load and hold.
- **Stall counter:** `stall_cnt` increments by 1 on each edge where `out_valid` && !`out_ready`.
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by reset. Flush does not clear it.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `out_ctrl` = 0, `stall_cnt` = 0, internal entries invalid.
  - `in_ready` = 1 after reset deassertion.
- Reset asserted mid-transfer discards all entries immediately (asynchronous).

## Timing
- Latency: 1 cycle from an input transfer to `out_valid` when the stage is empty.
- Throughput: 1 entry/cycle while `out_ready` = 1.
- Without the skid option: `in_ready` = !`out_valid` || `out_ready`. This is combinational and depends on `out_ready` in the same cycle.
- With the skid option: `in_ready` = !`skid_valid`, a registered signal with no combinational path from `out_ready`.
- `in_ready` does not depend on `flush`.
- `out_*` are always registered outputs.

## Configuration
- **`PIPE_SKID_EN` defined:** adds a one-entry skid register.
  - An input transfer that arrives while the main entry is held (`out_valid` && !`out_ready`) is captured in the skid. The skid then sets `skid_valid`, and `in_ready` = 0 from the next cycle.
  - When the main entry is consumed or empty, it loads from the skid first, which clears `skid_valid`. Otherwise it loads from the input as usual.
  - Ordering is preserved.
  - Capacity is 2 entries.
  - Flush clears both entries, so `in_ready` = 1 on the next cycle.
- **`PIPE_SKID_EN` undefined:** single entry, combinational `in_ready` as in Timing, capacity 1.

## Test plan
- **Reset:** assert `reset` mid-cycle with `out_valid` = 1 → `out_valid`, `out_ctrl`, `out_data` and `stall_cnt` are all 0 immediately. After release, `in_ready` = 1.
- **Streaming:** `out_ready` = 1, drive entries with `in_data` = 1, 2, 3 on consecutive cycles → `out_data` = 1, 2, 3 one cycle later, `out_valid` continuously 1.
- **Back-pressure:**
  - Hold `out_ready` = 0 for 4 cycles with `out_data` = 5 → `out_data` stays 5 and `stall_cnt` = 4.
  - Skid build: the second entry (6) is captured, `in_ready` drops the next cycle, and release yields 5 then 6.
  - Non-skid build: `in_ready` = 0 throughout.
- **Flush:** `flush` = 1 with `out_valid` = 1, `out_ctrl` = 6'h3F and `in_valid` = 1 → next cycle `out_valid` = 0 and `out_ctrl` = 0, and the input entry never appears at the output.
- **Bubble:** `in_valid` = 0, `out_ready` = 1 after entry `in_ctrl` = 6'h21 → next cycle `out_valid` = 0, `out_ctrl` = 0, `out_data` unchanged.
- **Saturation:** CNT_W = 4, stall for 20 cycles → `stall_cnt` holds 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: data + control bundles, valid/ready handshake,
// synchronous flush to a bubble, saturating stall counter. Define PIPE_SKID_EN for a registered-ready skid entry.
module pipe_stage_reg #(
  parameter int DATA_W = 104,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_xfer;
  logic w_load;
  logic w_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == {CNT_W{1'b1}}) ? v : v + one;
  endfunction

  assign w_load  = !r_out_valid || out_ready;
  assign w_stall = r_out_valid && !out_ready;

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // Ready comes only from the skid flag, so out_ready has no path to in_ready.
  assign in_ready  = !r_skid_valid;
  assign w_in_xfer = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_stall_cnt  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_out_ctrl   <= '0;
        r_skid_valid <= 1'b0;
      end else if (w_load) begin
        // Skid holds the older entry, so it drains ahead of any new input.
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_ctrl   <= r_skid_ctrl;
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data;
          r_out_ctrl  <= in_ctrl;
        end else begin
          r_out_valid <= 1'b0;
          r_out_ctrl  <= '0;
        end
      end else if (w_in_xfer) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data;
        r_skid_ctrl  <= in_ctrl;
      end
    end
  end
`else
  assign in_ready  = w_load;
  assign w_in_xfer = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (flush) begin
        r_out_valid <= 1'b0;
        r_out_ctrl  <= '0;
      end else if (w_load) begin
        if (w_in_xfer) begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data;
          r_out_ctrl  <= in_ctrl;
        end else begin
          // Bubble: control is zeroed, data is left as-is.
          r_out_valid <= 1'b0;
          r_out_ctrl  <= '0;
        end
      end
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign stall_cnt = r_stall_cnt;

endmodule
